// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED Hamming encoder: state encoding, sizes and
// the parity/packing functions shared by the encoder and the decoder.
package hamming_pkg;

    localparam int MSG_BITS = 11;
    localparam int CW_BITS  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_CAP   = 3'd3,
        ST_WR_LO = 3'd4,
        ST_WR_HI = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Returns {p8, p4, p2, p1, p0}; p0 covers data and the four Hamming bits.
    function automatic logic [4:0] enc_parity(input logic [MSG_BITS:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {p8, p4, p2, p1, p0};
    endfunction

    function automatic logic [CW_BITS-1:0] pack_codeword(input logic [MSG_BITS:1] d);
        logic [4:0] p;
        p = enc_parity(d);
        return {d[11:5], p[4], d[4:2], p[3], d[1], p[2], p[1], p[0]};
    endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational 11-bit message to 16-bit SECDED codeword encoder.
module hamming_enc_core
    import hamming_pkg::*;
(
    input  logic [MSG_BITS:1]  i_data,
    output logic [CW_BITS-1:0] o_codeword
);

    assign o_codeword = pack_codeword(i_data);

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-walking SECDED encoder: reads NUM_MSG raw messages, writes codewords.
// All outputs are registered and decoded from the next state.
module hamming_enc_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata
);

    localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);

    state_t              r_state, w_state_d;
    logic [IDX_W-1:0]    r_idx, w_idx_d;
    logic [7:0]          r_lo, w_lo_d;
    logic [2:0]          r_hi, w_hi_d;
    logic [ADDR_W-1:0]   w_addr_d;
    logic                w_rd_d, w_wr_d, w_done_d, w_busy_d;
    logic [7:0]          w_wdata_d;
    logic [CW_BITS-1:0]  w_cw;
    logic [ADDR_W-1:0]   w_off, w_src, w_dst;

    // The codeword is formed from the next-cycle data registers so that the
    // registered write data lines up with the WR_LO/WR_HI states.
    hamming_enc_core u_core (
        .i_data     ({w_hi_d, w_lo_d}),
        .o_codeword (w_cw)
    );

    assign w_off = ADDR_W'({w_idx_d, 1'b0});
    assign w_src = ADDR_W'(SRC_BASE) + w_off;
    assign w_dst = ADDR_W'(DST_BASE) + w_off;

    // Next-state, message counter and data capture.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_lo_d    = r_lo;
        w_hi_d    = r_hi;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    w_state_d = ST_RD_LO;
                    w_idx_d   = {IDX_W{1'b0}};
                end else begin
                    w_state_d = r_state;
                end
            end
            ST_RD_LO: w_state_d = ST_RD_HI;
            ST_RD_HI: begin
                w_lo_d    = mem_rdata;
                w_state_d = ST_CAP;
            end
            ST_CAP: begin
                w_hi_d    = mem_rdata[2:0];
                w_state_d = ST_WR_LO;
            end
            ST_WR_LO: w_state_d = ST_WR_HI;
            ST_WR_HI: begin
                if (r_idx == LAST_IDX) begin
                    w_state_d = ST_DONE;
                end else begin
                    w_idx_d   = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                    w_state_d = ST_RD_LO;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state, registered below.
    always_comb begin
        w_addr_d  = {ADDR_W{1'b0}};
        w_rd_d    = 1'b0;
        w_wr_d    = 1'b0;
        w_wdata_d = 8'h00;
        w_done_d  = 1'b0;
        w_busy_d  = 1'b0;
        case (w_state_d)
            ST_RD_LO: begin
                w_addr_d = w_src;
                w_rd_d   = 1'b1;
                w_busy_d = 1'b1;
            end
            ST_RD_HI: begin
                w_addr_d = w_src + {{(ADDR_W-1){1'b0}}, 1'b1};
                w_rd_d   = 1'b1;
                w_busy_d = 1'b1;
            end
            ST_CAP:   w_busy_d = 1'b1;
            ST_WR_LO: begin
                w_addr_d  = w_dst;
                w_wr_d    = 1'b1;
                w_wdata_d = w_cw[7:0];
                w_busy_d  = 1'b1;
            end
            ST_WR_HI: begin
                w_addr_d  = w_dst + {{(ADDR_W-1){1'b0}}, 1'b1};
                w_wr_d    = 1'b1;
                w_wdata_d = w_cw[15:8];
                w_busy_d  = 1'b1;
            end
            ST_DONE:  w_done_d = 1'b1;
            default:  w_done_d = 1'b0;
        endcase
    end

    // State, data and output registers with asynchronous abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= {IDX_W{1'b0}};
            r_lo      <= 8'h00;
            r_hi      <= 3'b000;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= 8'h00;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_lo      <= w_lo_d;
            r_hi      <= w_hi_d;
            mem_addr  <= w_addr_d;
            mem_rd_en <= w_rd_d;
            mem_wr_en <= w_wr_d;
            mem_wdata <= w_wdata_d;
            done      <= w_done_d;
            busy      <= w_busy_d;
        end
    end

endmodule

// File: doc/hamming_enc_engine.md
Name: hamming_enc_engine

Overview:
- Hardware SECDED Hamming encoder engine; the upstream stage of the program-2 decoder.
- It walks data memory, reads NUM_MSG 11-bit raw messages and computes 4 Hamming parity bits plus 1 overall parity bit for each.
- It writes the resulting 16-bit codewords back into the memory region the decoder later reads.
- It sits beside the core on the data-memory port and is started by the same req/done handshake as a program.

Parameters:
- NUM_MSG, 15, number of messages processed per run.
- SRC_BASE, 0, byte address of message 0 low byte.
- DST_BASE, 30, byte address of codeword 0 low byte.
- ADDR_W, 8, data-memory byte-address width.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- req, input, 1, start request; sampled high in IDLE or DONE starts a run.
- done, output, 1, high while in DONE.
- busy, output, 1, high from the first RD_LO through the last WR_HI.
- mem_addr, output, ADDR_W, byte address.
- mem_rd_en, output, 1, read strobe; read data is valid the next cycle.
- mem_rdata, input, 8, registered read data.
- mem_wr_en, output, 1, write strobe; the write commits on that edge.
- mem_wdata, output, 8, write data.

Behaviour:
- Source layout, message i:
  - mem[SRC_BASE+2i] = d[8:1].
  - mem[SRC_BASE+2i+1][2:0] = d[11:9]; bits [7:3] are ignored.
- Parity:
  - p8 = ^d[11:5].
  - p4 = ^d[11:8] ^ ^d[4:2].
  - p2 = d11^d10^d7^d6^d4^d3^d1.
  - p1 = d11^d9^d7^d5^d4^d2^d1.
  - p0 = ^d ^ p8 ^ p4 ^ p2 ^ p1.
- Codeword = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
  - Low byte goes to mem[DST_BASE+2i].
  - High byte goes to mem[DST_BASE+2i+1].
- FSM states: IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE.
  - IDLE/DONE with req=1 -> RD_LO, i=0, done cleared.
  - RD_LO: addr=SRC_BASE+2i, rd_en=1.
  - RD_HI: addr=SRC_BASE+2i+1, rd_en=1; capture mem_rdata into lo register.
  - CAP: capture mem_rdata[2:0] into hi register.
  - WR_LO: addr=DST_BASE+2i, wr_en=1, wdata = codeword[7:0].
  - WR_HI: addr=DST_BASE+2i+1, wr_en=1, wdata = codeword[15:8].
  - WR_HI exits: if i==NUM_MSG-1 -> DONE, else i++ and -> RD_LO.
- Latency: 5 cycles per message. With req sampled at edge E0, done rises after edge E(5*NUM_MSG), which is E75 at the defaults.
- Strobes are mutually exclusive; mem_rd_en and mem_wr_en are never high together.
- Outside RD_*/WR_* states, mem_addr=0 and mem_wdata=0.
- Address arithmetic is modulo 2^ADDR_W; wrap is permitted and not flagged.
- req while busy is ignored.
- req held high in DONE starts a new run immediately (done drops on the following edge).
- Reset: asynchronous.
  - State -> IDLE, i=0, data registers=0.
  - done=0, busy=0, all mem strobes/addr/wdata=0.
  - Reset mid-run aborts with no further writes; already-written bytes stay as written.
- Counter width is clog2(NUM_MSG); it is compared against NUM_MSG-1, never overflows.

Decomposition:
- Shared package hamming_pkg holds:
  - the state enum;
  - the functions enc_parity (11b -> 5b) and pack_codeword (11b -> 16b);
  - the constants MSG_BITS=11 and CW_BITS=16.
- One natural sub-module: hamming_enc_core, purely combinational d[11:1] -> codeword[15:0]. It is reusable by the decoder for syndrome generation.
- The FSM, counter and memory sequencing stay in hamming_enc_engine.

Test Plan:
- d=11'h000 in msg 0 (mem[0]=8'h00, mem[1]=8'h00) -> mem[30]=8'h00, mem[31]=8'h00.
- d=11'h7FF (mem[0]=8'hFF, mem[1]=8'h07) -> codeword 16'hFFFF: mem[30]=8'hFF, mem[31]=8'hFF.
- d=11'h001 -> 16'h000F.
- d=11'h400 (mem[1]=8'h04) -> 16'h8117: mem[30]=8'h17, mem[31]=8'h81.
- mem[1]=8'hF8 garbage in the upper bits -> treated as d[11:9]=0, output identical to d=0.
- 15 random messages, req pulse at E0:
  - done first high after E75 and stays high; busy high cycles E1..E75.
  - Every output word matches the reference parity model.
  - No write outside bytes 30..59.
  - mem[0..29] unchanged.
- Assert reset low at cycle 23 (mid message 4):
  - All outputs go 0 immediately.
  - No writes after reset.
  - A new req re-runs from message 0 and produces correct results.
- req held high through the run and into DONE:
  - No restart while busy.
  - A second run starts the edge after DONE is entered.
